// File: rtl/video_led_map_if.sv
// Pixel, table-write and LED-result bus of video_led_map.
// slave is the map's side of the bus; master is the driver's side.
interface video_led_map_if #(
  parameter int C_LED_N = 18,
  parameter int C_HW    = 9,
  parameter int C_VW    = 8
);
  logic                    CK_EE_i;
  logic [C_HW-1:0]         HCTRs_i;
  logic [C_VW-1:0]         VCTRs_i;
  logic [C_LED_N-1:0]      LEDs_ON_i;
  logic [C_LED_N-1:0]      BLINKs_i;
  logic                    FRAME_i;
  logic                    WR_i;
  logic [4:0]              WR_ADRs_i;
  logic [C_HW+C_VW+3:0]    WR_DATs_i;
  logic                    LED_HIT_o;
  logic [4:0]              LED_IDXs_o;
  logic                    LED_COLOR_ON_o;
  logic [2:0]              LED_COLOR_PHs_o;

  modport slave (
    input  CK_EE_i, HCTRs_i, VCTRs_i, LEDs_ON_i, BLINKs_i, FRAME_i,
    input  WR_i, WR_ADRs_i, WR_DATs_i,
    output LED_HIT_o, LED_IDXs_o, LED_COLOR_ON_o, LED_COLOR_PHs_o
  );

  modport master (
    output CK_EE_i, HCTRs_i, VCTRs_i, LEDs_ON_i, BLINKs_i, FRAME_i,
    output WR_i, WR_ADRs_i, WR_DATs_i,
    input  LED_HIT_o, LED_IDXs_o, LED_COLOR_ON_o, LED_COLOR_PHs_o
  );
endinterface

// File: rtl/video_led_map.sv
// Maps the current pixel onto a run-time writable table of LED footprints (2-stage pipeline).
// Optional frame-driven blinking is compiled in with `define VIDEO_LED_MAP_BLINK_EN.
module video_led_map #(
  parameter int                   C_LED_N    = 18,
  parameter int                   C_HW       = 9,
  parameter int                   C_VW       = 8,
  parameter int                   C_RAD      = 7,
  parameter int                   C_CUT      = 11,
  parameter logic [C_LED_N*24-1:0] C_LOC_INIT = '0,
  parameter logic [C_LED_N*4-1:0]  C_COL_INIT = '0,
  parameter int                   C_BLINK_W  = 5
) (
  input  logic              CK_i,
  input  logic              SRST_i,
  video_led_map_if.slave    bus
);

  localparam int DW = ((C_HW > C_VW) ? C_HW : C_VW) + 2;
  localparam logic [DW-1:0] RAD = DW'(C_RAD);
  localparam logic [DW:0]   CUT = (DW+1)'(C_CUT);

  logic [C_HW-1:0]    x_tab   [C_LED_N];
  logic [C_VW-1:0]    y_tab   [C_LED_N];
  logic [3:0]         col_tab [C_LED_N];
  logic [C_LED_N-1:0] geo_hit;
  logic [C_LED_N-1:0] blink_mask;
  logic [C_LED_N-1:0] s1_hit;
  logic               win_any;
  logic               win_on;
  logic [4:0]         win_idx;
  logic [3:0]         win_col;

  // Table writes ignore the pixel enable; out-of-range indices are dropped.
  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      for (int i = 0; i < C_LED_N; i++) begin
        x_tab[i]   <= C_LOC_INIT[i*24 +: C_HW];
        y_tab[i]   <= C_LOC_INIT[i*24+12 +: C_VW];
        col_tab[i] <= C_COL_INIT[i*4 +: 4];
      end
    end else if (bus.WR_i && (int'(bus.WR_ADRs_i) < C_LED_N)) begin
      x_tab[bus.WR_ADRs_i]   <= bus.WR_DATs_i[C_HW-1:0];
      y_tab[bus.WR_ADRs_i]   <= bus.WR_DATs_i[C_HW +: C_VW];
      col_tab[bus.WR_ADRs_i] <= bus.WR_DATs_i[C_HW+C_VW +: 4];
    end
  end

  // Negative offsets fold to their one's complement, so the footprint spans -RAD-1..RAD.
  for (genvar g = 0; g < C_LED_N; g++) begin : g_geo
    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic [DW-1:0]        adx;
    logic [DW-1:0]        ady;
    logic [DW:0]          sum;

    assign dx  = $signed(DW'(bus.HCTRs_i)) - $signed(DW'(x_tab[g]));
    assign dy  = $signed(DW'(bus.VCTRs_i)) - $signed(DW'(y_tab[g]));
    assign adx = dx[DW-1] ? ~$unsigned(dx) : $unsigned(dx);
    assign ady = dy[DW-1] ? ~$unsigned(dy) : $unsigned(dy);
    assign sum = {1'b0, adx} + {1'b0, ady};
    assign geo_hit[g] = (adx <= RAD) && (ady <= RAD) && (sum < CUT);
  end

`ifdef VIDEO_LED_MAP_BLINK_EN
  logic [C_BLINK_W-1:0] blink_ctr;

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      blink_ctr <= '0;
    end else if (bus.FRAME_i) begin
      blink_ctr <= blink_ctr + 1'b1;
    end
  end

  assign blink_mask = blink_ctr[C_BLINK_W-1] ? bus.BLINKs_i : '0;
`else
  localparam int unused_blink_w = C_BLINK_W;
  logic unused_blink;

  assign unused_blink = ^{bus.BLINKs_i, bus.FRAME_i};
  assign blink_mask   = '0;
`endif

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      s1_hit <= '0;
    end else if (bus.CK_EE_i) begin
      s1_hit <= geo_hit & ~blink_mask;
    end
  end

  // Scanning downwards leaves the lowest set index as the winner.
  always_comb begin
    win_any = 1'b0;
    win_on  = 1'b0;
    win_idx = 5'h1F;
    win_col = '0;
    for (int i = C_LED_N-1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_any = 1'b1;
        win_on  = bus.LEDs_ON_i[i];
        win_idx = 5'(i);
        win_col = col_tab[i];
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      bus.LED_HIT_o       <= 1'b0;
      bus.LED_IDXs_o      <= 5'h1F;
      bus.LED_COLOR_ON_o  <= 1'b0;
      bus.LED_COLOR_PHs_o <= 3'h0;
    end else if (bus.CK_EE_i) begin
      bus.LED_HIT_o       <= win_any && win_on;
      bus.LED_IDXs_o      <= win_idx;
      bus.LED_COLOR_ON_o  <= win_any && win_on && win_col[3];
      bus.LED_COLOR_PHs_o <= (win_any && win_on) ? win_col[2:0] : 3'h0;
    end
  end

endmodule

// File: doc/video_led_map.md
VIDEO_LED_MAP -- requirements
Module: video_led_map

Interface
REQ-001 SHALL have parameters:
- C_LED_N, 18, LED count, 1..31.
- C_HW, 9, horizontal counter width.
- C_VW, 8, vertical counter width.
- C_RAD, 7, max |dx| and |dy| for a hit.
- C_CUT, 11, corner-cut threshold.
- C_LOC_INIT, C_LED_N*24 bits, reset table; per LED {Y[23:12], X[11:0]}, LED0 at LSB.
- C_COL_INIT, C_LED_N*4 bits, reset colour; per LED {COLOR_ON, PH[2:0]}.
- C_BLINK_W, 5, blink frame-counter width.
REQ-002 SHALL have ports:
- CK_i, in, 1, clock.
- SRST_i, in, 1, synchronous active-high reset.
- CK_EE_i, in, 1, pixel clock enable.
- HCTRs_i, in, C_HW, pixel X.
- VCTRs_i, in, C_VW, pixel Y.
- LEDs_ON_i, in, C_LED_N, per-LED lit flag.
- BLINKs_i, in, C_LED_N, per-LED blink enable.
- FRAME_i, in, 1, one-cycle frame-start pulse.
- WR_i, in, 1, table write strobe.
- WR_ADRs_i, in, 5, LED index to write.
- WR_DATs_i, in, C_HW+C_VW+4, {COLOR_ON, PH[2:0], Y, X}.
- LED_HIT_o, out, 1, pixel is inside a lit LED.
- LED_IDXs_o, out, 5, winning LED index; 5'h1F = none.
- LED_COLOR_ON_o, out, 1, colour enable of the hit LED.
- LED_COLOR_PHs_o, out, 3, colour phase of the hit LED.
REQ-003 SHALL use one clock CK_i; reset SRST_i is synchronous and active-high.

Function
REQ-004 SHALL hold a location/colour table register per LED, writable at run time.
REQ-005 On WR_i=1 with WR_ADRs_i<C_LED_N, SHALL update that entry at the clock edge, independent of CK_EE_i; WR_ADRs_i>=C_LED_N SHALL be ignored.
REQ-006 For each LED, SHALL compute dx=HCTRs_i-X and dy=VCTRs_i-Y in signed width max(C_HW,C_VW)+2; a negative value SHALL map to its one's complement (-d-1).
REQ-007 Hit condition: adx<=C_RAD AND ady<=C_RAD AND (adx+ady)<C_CUT, using full-width arithmetic with no truncation.
REQ-008 Pipeline stage 1 (CK_EE_i=1) SHALL register the C_LED_N-bit geometric hit vector, gated by the blink mask (REQ-016), using table contents as they stood before that edge.
REQ-009 Stage 2 (CK_EE_i=1) SHALL register all outputs from the stage-1 vector.
REQ-010 Total latency SHALL be 2 CK_EE_i-qualified cycles from HCTRs_i/VCTRs_i to outputs; stages SHALL hold while CK_EE_i=0.
REQ-011 Priority: when the vector is nonzero, the lowest set index SHALL win and LED_IDXs_o SHALL equal that index; with no hit, LED_IDXs_o=5'h1F.
REQ-012 LED_HIT_o=LEDs_ON_i[idx] sampled at stage 2; an unlit winner SHALL occlude higher indices (LED_HIT_o=0, LED_IDXs_o=idx).
REQ-013 LED_COLOR_ON_o and LED_COLOR_PHs_o SHALL equal the winner's table colour when LED_HIT_o=1, else 0.
REQ-014 A write to the table entry being judged SHALL take effect from the next stage-1 edge; no partial-entry mix SHALL occur.

Reset
REQ-015 When SRST_i=1 at an edge, SHALL load C_LOC_INIT/C_COL_INIT into the table, clear the stage-1 vector and blink counter, and set LED_HIT_o=0, LED_IDXs_o=5'h1F, LED_COLOR_ON_o=0, LED_COLOR_PHs_o=0; reset SHALL override WR_i and CK_EE_i.

Configuration
REQ-016 With VIDEO_LED_MAP_BLINK_EN defined: a C_BLINK_W-bit counter SHALL increment (wrapping) on each FRAME_i=1 edge, and LED i's stage-1 hit bit SHALL be forced 0 when BLINKs_i[i]=1 and the counter MSB=1.
REQ-017 With VIDEO_LED_MAP_BLINK_EN undefined, the counter SHALL NOT exist, and BLINKs_i and FRAME_i SHALL be ignored.

Verification
REQ-018 Reset, CK_EE_i=1, LED0 at (0x0C8,0x038), LEDs_ON_i[0]=1, pixel (0x0C8,0x038) -> 2 cycles later LED_HIT_o=1, LED_IDXs_o=0, PH=3'h2.
REQ-019 Same LED, pixel (0x0CF,0x03C) (adx=7, ady=4, sum 11) -> LED_HIT_o=0, LED_IDXs_o=5'h1F; pixel (0x0C1,0x038) (adx=6) -> hit.
REQ-020 Write LED3 to (0x010,0x010) with colour {1,3'h5}, then pixel (0x010,0x010) -> LED_IDXs_o=3, PH=5; the same write to WR_ADRs_i=31 -> no table change.
REQ-021 LED1 and LED2 overlap with LEDs_ON_i[1]=0 -> LED_IDXs_o=1, LED_HIT_o=0, colour outputs 0.
REQ-022 BLINK_EN, BLINKs_i[0]=1, 16 FRAME_i pulses with C_BLINK_W=5 -> LED0 hits suppressed until the 32nd pulse wraps the counter; undefined -> never suppressed.
REQ-023 CK_EE_i toggled 1/0 during a hit -> outputs change only on enabled edges; SRST_i mid-stream -> outputs reset at that edge.
